sum_uart_sender: RTL and testbench

SUM_UART_SENDER -- requirements
Module: sum_uart_sender

---
 rtl/filter_pkg.sv | 21 ++
 rtl/sum_uart_sender.sv | 139 +++++++++++++
 tb/tb_sum_uart_sender.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/filter_pkg.sv
// Shared definitions for the sum UART sender: widths, defaults and FSM states.
package filter_pkg;

    localparam int unsigned SUM_W        = 40;
    localparam int unsigned NUM_SUMS_DEF = 768;
    localparam int unsigned SUM_ADDR_W   = 10;
    localparam int unsigned BYTE_W       = 8;
    localparam logic [BYTE_W-1:0] DELIM_BYTE = 8'h0A;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        LOAD,
        SEND,
        GAP,
        NEXT,
        DONE
    } sender_state_t;

endpackage

// File: rtl/sum_uart_sender.sv
// Streams NUM_SUMS 40-bit sums from the sum RAM to a byte-wide UART, MSB first.
// Optional macro SUM_SENDER_DELIM_EN appends a newline byte after every sum.
module sum_uart_sender
    import filter_pkg::*;
#(
    parameter int unsigned NUM_SUMS = NUM_SUMS_DEF,
    parameter int unsigned RD_LAT   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  sum_read_en,
    output logic [SUM_ADDR_W-1:0] sum_read_addr,
    input  logic [SUM_W-1:0]      sum_ram_data_out,
    input  logic                  tx_rdy,
    output logic                  tx_en,
    output logic [BYTE_W-1:0]     tx_data,
    output logic                  busy,
    output logic                  done
);

`ifdef SUM_SENDER_DELIM_EN
    localparam int unsigned BYTES_PER_WORD = 6;
`else
    localparam int unsigned BYTES_PER_WORD = 5;
`endif
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [SUM_ADDR_W-1:0] LAST_ADDR = SUM_ADDR_W'(NUM_SUMS - 1);
    localparam logic [WAIT_W-1:0]     LAST_WAIT = WAIT_W'(RD_LAT - 1);

    sender_state_t         state;
    logic [SUM_ADDR_W-1:0] addr_cnt;
    logic [IDX_W-1:0]      byte_idx;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [SUM_W-1:0]      word_q;
    logic [BYTE_W-1:0]     tx_byte_c;

    // Byte select for the current index, most significant byte first
    always_comb begin
        tx_byte_c = word_q[39:32];
        case (byte_idx)
            3'd0:    tx_byte_c = word_q[39:32];
            3'd1:    tx_byte_c = word_q[31:24];
            3'd2:    tx_byte_c = word_q[23:16];
            3'd3:    tx_byte_c = word_q[15:8];
            3'd4:    tx_byte_c = word_q[7:0];
`ifdef SUM_SENDER_DELIM_EN
            3'd5:    tx_byte_c = DELIM_BYTE;
`endif
            default: tx_byte_c = word_q[39:32];
        endcase
    end

    // Control FSM: read a sum, wait out the RAM latency, then hand bytes to the UART
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            addr_cnt      <= '0;
            byte_idx      <= '0;
            wait_cnt      <= '0;
            word_q        <= '0;
            sum_read_en   <= 1'b0;
            sum_read_addr <= '0;
            tx_en         <= 1'b0;
            tx_data       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            sum_read_en <= 1'b0;
            tx_en       <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_cnt      <= '0;
                        busy          <= 1'b1;
                        sum_read_en   <= 1'b1;
                        sum_read_addr <= '0;
                        state         <= READ;
                    end
                end
                READ: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == LAST_WAIT) begin
                        state <= LOAD;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                LOAD: begin
                    word_q   <= sum_ram_data_out;
                    byte_idx <= '0;
                    state    <= SEND;
                end
                SEND: begin
                    if (tx_rdy) begin
                        tx_en   <= 1'b1;
                        tx_data <= tx_byte_c;
                        state   <= GAP;
                    end
                end
                // UART still shows ready for a cycle after tx_en; do not look at it here
                GAP: begin
                    if (byte_idx == LAST_IDX) begin
                        state <= NEXT;
                    end else begin
                        byte_idx <= byte_idx + IDX_W'(1);
                        state    <= SEND;
                    end
                end
                NEXT: begin
                    if (addr_cnt == LAST_ADDR) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        addr_cnt      <= addr_cnt + SUM_ADDR_W'(1);
                        sum_read_en   <= 1'b1;
                        sum_read_addr <= addr_cnt + SUM_ADDR_W'(1);
                        state         <= READ;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_uart_sender.sv
// Scoreboard bench for sum_uart_sender: a two-sum instance for handshake and
// reset scenarios plus a default-size instance streaming RAM[n]=n.
module tb_sum_uart_sender;

`ifdef SUM_SENDER_DELIM_EN
    localparam int BPW = 6;
`else
    localparam int BPW = 5;
`endif

    logic clk;

    // Small instance (NUM_SUMS=2)
    logic        reset_a, start_a, sum_read_en_a, tx_rdy_a, tx_en_a, busy_a, done_a;
    logic [9:0]  sum_read_addr_a;
    logic [39:0] ram_out_a;
    logic [7:0]  tx_data_a;
    logic [39:0] ram_a [2];
    logic [9:0]  pipe_a0, pipe_a1;

    // Default instance (NUM_SUMS=768)
    logic        reset_b, start_b, sum_read_en_b, tx_rdy_b, tx_en_b, busy_b, done_b;
    logic [9:0]  sum_read_addr_b;
    logic [39:0] ram_out_b;
    logic [7:0]  tx_data_b;
    logic [9:0]  pipe_b0, pipe_b1;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_q [$];
    int   en_cnt_a = 0, done_cnt_a = 0, viol_a = 0, gap_a = 0;
    logic prev_en_a = 1'b0, rdy_q_a = 1'b1, slow_a = 1'b0;

    int          en_cnt_b = 0, done_cnt_b = 0, max_addr_b = 0, saw_768_b = 0;
    logic [63:0] hist_b = '0;

    sum_uart_sender #(.NUM_SUMS(2), .RD_LAT(2)) dut_a (
        .clk             (clk),
        .reset           (reset_a),
        .start           (start_a),
        .sum_read_en     (sum_read_en_a),
        .sum_read_addr   (sum_read_addr_a),
        .sum_ram_data_out(ram_out_a),
        .tx_rdy          (tx_rdy_a),
        .tx_en           (tx_en_a),
        .tx_data         (tx_data_a),
        .busy            (busy_a),
        .done            (done_a)
    );

    sum_uart_sender dut_b (
        .clk             (clk),
        .reset           (reset_b),
        .start           (start_b),
        .sum_read_en     (sum_read_en_b),
        .sum_read_addr   (sum_read_addr_b),
        .sum_ram_data_out(ram_out_b),
        .tx_rdy          (tx_rdy_b),
        .tx_en           (tx_en_b),
        .tx_data         (tx_data_b),
        .busy            (busy_b),
        .done            (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models with a two-cycle address-to-data latency
    always @(posedge clk) begin
        pipe_a0 <= sum_read_addr_a;
        pipe_a1 <= pipe_a0;
        pipe_b0 <= sum_read_addr_b;
        pipe_b1 <= pipe_b0;
    end
    assign ram_out_a = ram_a[pipe_a1[0]];
    assign ram_out_b = 40'(pipe_b1);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [39:0] w);
        for (int i = 4; i >= 0; i--) exp_q.push_back(w[i*8 +: 8]);
`ifdef SUM_SENDER_DELIM_EN
        exp_q.push_back(8'h0A);
`endif
    endtask

    task automatic pulse_start_a();
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("busy_after_start", 64'(busy_a), 64'd1);
    endtask

    task automatic wait_done_a(input string tag, input int budget);
        int n = 0;
        while (!done_a && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(done_a), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_read_en"}, 64'(sum_read_en_a), 64'd0);
        check({tag, "_addr"},    64'(sum_read_addr_a), 64'd0);
        check({tag, "_tx_en"},   64'(tx_en_a), 64'd0);
        check({tag, "_tx_data"}, 64'(tx_data_a), 64'd0);
        check({tag, "_busy"},    64'(busy_a), 64'd0);
        check({tag, "_done"},    64'(done_a), 64'd0);
    endtask

    // UART model A: always ready, or ready only after 20 idle cycles following each byte
    initial begin
        tx_rdy_a = 1'b1;
        forever begin
            @(negedge clk);
            if (!slow_a) begin
                tx_rdy_a = 1'b1;
            end else if (tx_en_a) begin
                tx_rdy_a = 1'b0;
                gap_a    = 0;
            end else if (gap_a < 20) begin
                tx_rdy_a = 1'b0;
                gap_a++;
            end else begin
                tx_rdy_a = 1'b1;
            end
        end
    end

    // UART model B: busy for one cycle after each byte
    initial begin
        tx_rdy_b = 1'b1;
        forever begin
            @(negedge clk);
            tx_rdy_b = !tx_en_b;
        end
    end

    initial forever begin
        @(posedge clk);
        rdy_q_a = tx_rdy_a;
    end

    // Monitor A: scoreboard compare and handshake rule tracking
    initial forever begin
        @(negedge clk);
        if (tx_en_a) begin
            en_cnt_a++;
            if (prev_en_a || !rdy_q_a) viol_a++;
            if (exp_q.size() == 0) check("byte_extra", 64'(exp_q.size()), 64'd1);
            else check("byte", 64'(tx_data_a), 64'(exp_q.pop_front()));
        end
        if (done_a) done_cnt_a++;
        prev_en_a = tx_en_a;
    end

    // Monitor B: byte history, address range, done count
    initial forever begin
        @(negedge clk);
        if (tx_en_b) begin
            en_cnt_b++;
            hist_b = {hist_b[55:0], tx_data_b};
        end
        if (sum_read_en_b) begin
            if (int'(sum_read_addr_b) > max_addr_b) max_addr_b = int'(sum_read_addr_b);
            if (sum_read_addr_b == 10'd768) saw_768_b = 1;
        end
        if (done_b) done_cnt_b++;
    end

    initial begin
        int en0, d0, k, n;
        reset_a = 1'b1;
        reset_b = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        ram_a[0] = 40'h0102030405;
        ram_a[1] = 40'hA1B2C3D4E5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        reset_a = 1'b0;
        reset_b = 1'b0;

        // Long default-size run proceeds in parallel with the small-instance tests
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check("b_busy_after_start", 64'(busy_b), 64'd1);

        // Ready stuck high
        push_word(ram_a[0]);
        push_word(ram_a[1]);
        en0 = en_cnt_a;
        d0  = done_cnt_a;
        pulse_start_a();
        wait_done_a("t1_done", 300);
        repeat (4) @(negedge clk);
        check("t1_bytes", 64'(en_cnt_a - en0), 64'(2 * BPW));
        check("t1_q_empty", 64'(exp_q.size()), 64'd0);
        check("t1_done_cnt", 64'(done_cnt_a - d0), 64'd1);
        check("t1_busy_low", 64'(busy_a), 64'd0);

        // Ready held low 20 cycles before every byte
        slow_a = 1'b1;
        push_word(ram_a[0]);
        push_word(ram_a[1]);
        en0 = en_cnt_a;
        d0  = done_cnt_a;
        pulse_start_a();
        wait_done_a("t2_done", 2000);
        repeat (4) @(negedge clk);
        slow_a = 1'b0;
        check("t2_bytes", 64'(en_cnt_a - en0), 64'(2 * BPW));
        check("t2_q_empty", 64'(exp_q.size()), 64'd0);
        check("t2_done_cnt", 64'(done_cnt_a - d0), 64'd1);
        check("t2_handshake_viol", 64'(viol_a), 64'd0);

        // Extra starts while busy and in the done cycle are ignored
        push_word(ram_a[0]);
        push_word(ram_a[1]);
        en0 = en_cnt_a;
        d0  = done_cnt_a;
        pulse_start_a();
        repeat (5) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (12) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a("t3_done", 300);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (40) @(negedge clk);
        check("t3_bytes", 64'(en_cnt_a - en0), 64'(2 * BPW));
        check("t3_done_cnt", 64'(done_cnt_a - d0), 64'd1);
        check("t3_busy_low", 64'(busy_a), 64'd0);

        // Reset right after the third byte of a run
        push_word(ram_a[0]);
        push_word(ram_a[1]);
        en0 = en_cnt_a;
        d0  = done_cnt_a;
        pulse_start_a();
        k = 0;
        n = 0;
        while (k < 3 && n < 300) begin
            @(negedge clk);
            if (tx_en_a) k++;
            n++;
        end
        check("t4_third_byte_seen", 64'(k), 64'd3);
        reset_a = 1'b1;
        @(negedge clk);
        check_reset_outputs("t4_rst");
        repeat (2) @(negedge clk);
        reset_a = 1'b0;
        exp_q.delete();
        repeat (60) @(negedge clk);
        check("t4_no_more_bytes", 64'(en_cnt_a - en0), 64'd3);
        check("t4_no_done", 64'(done_cnt_a - d0), 64'd0);
        check("t4_idle_busy", 64'(busy_a), 64'd0);

        push_word(ram_a[0]);
        push_word(ram_a[1]);
        en0 = en_cnt_a;
        d0  = done_cnt_a;
        pulse_start_a();
        check("t4_restart_read_en", 64'(sum_read_en_a), 64'd1);
        check("t4_restart_addr", 64'(sum_read_addr_a), 64'd0);
        wait_done_a("t4_done", 300);
        repeat (4) @(negedge clk);
        check("t4_bytes", 64'(en_cnt_a - en0), 64'(2 * BPW));
        check("t4_q_empty", 64'(exp_q.size()), 64'd0);

        // All-ones words
        ram_a[0] = 40'hFFFFFFFFFF;
        ram_a[1] = 40'hFFFFFFFFFF;
        push_word(ram_a[0]);
        push_word(ram_a[1]);
        en0 = en_cnt_a;
        pulse_start_a();
        wait_done_a("t5_done", 300);
        repeat (4) @(negedge clk);
        check("t5_bytes", 64'(en_cnt_a - en0), 64'(2 * BPW));
        check("t5_q_empty", 64'(exp_q.size()), 64'd0);
        check("handshake_viol_total", 64'(viol_a), 64'd0);

        // Default-size run: last bytes, address range, single done
        n = 0;
        while (done_cnt_b == 0 && n < 40000) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        check("b_done_cnt", 64'(done_cnt_b), 64'd1);
        check("b_bytes", 64'(en_cnt_b), 64'(768 * BPW));
        check("b_max_addr", 64'(max_addr_b), 64'd767);
        check("b_no_addr_768", 64'(saw_768_b), 64'd0);
        check("b_busy_low", 64'(busy_b), 64'd0);
`ifdef SUM_SENDER_DELIM_EN
        check("b_tail", 64'(hist_b[47:0]), 64'h00000002FF0A);
`else
        check("b_tail", 64'(hist_b[39:0]), 64'h00000002FF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
